// File: rtl/mdu_pkg.sv
// Shared MDU definitions for the D-stage decoder, the hazard unit and the E-stage MDU.
// Contents:
//   mdu_op_e         3-bit MDU op encodings (MDU_NONE..MDU_MTLO; 7 is reserved and acts as NONE)
//   MULT_CYCLES_DEF  default busy window for MULT/MULTU
//   DIV_CYCLES_DEF   default busy window for DIV/DIVU
//   CNT_W            width of the busy-window counter
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

  // True for ops that open a multi-cycle busy window.
  function automatic logic is_long_op(logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// The result of MULT/MULTU/DIV/DIVU is computed at issue, parked in pend_hi/pend_lo and
// committed to HI/LO when the busy counter runs out. MTHI/MTLO write in one edge.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      E-stage instruction is an MDU op
//   op         MDU op encoding (mdu_pkg::mdu_op_e)
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   busy       multi-cycle op in flight (registered)
//   stall_req  busy, or a multiply/divide is being issued this cycle
//   hi, lo     architectural HI/LO
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             pend_valid_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic [31:0]      hi_q, lo_q;

  // Arithmetic, evaluated combinationally on the issue-cycle operands.
  logic        is_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (op == MDU_MULT) || (op == MDU_DIV);

    // One 64x64 truncated multiplier serves both: extension choice selects signedness.
    mul_a = is_signed ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    mul_b = is_signed ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    prod  = mul_a * mul_b;

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    a_neg  = is_signed & rs_val[31];
    b_neg  = is_signed & rt_val[31];
    a_mag  = a_neg ? (32'd0 - rs_val) : rs_val;
    b_mag  = b_neg ? (32'd0 - rt_val) : rt_val;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else if (cnt_q != '0) begin
      // RUN: any start is ignored; commit on the 1 -> 0 step.
      cnt_q  <= cnt_q - 1'b1;
      busy_q <= (cnt_q != CNT_W'(1));
      if (cnt_q == CNT_W'(1) && pend_valid_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (start) begin
      case (mdu_op_e'(op))
        MDU_MULT, MDU_MULTU: begin
          pend_hi_q    <= prod[63:32];
          pend_lo_q    <= prod[31:0];
          pend_valid_q <= 1'b1;
          cnt_q        <= MultLoad;
          busy_q       <= 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero still spends the busy window but leaves HI/LO untouched.
          pend_hi_q    <= rem;
          pend_lo_q    <= quot;
          pend_valid_q <= (rt_val != 32'd0);
          cnt_q        <= DivLoad;
          busy_q       <= 1'b1;
        end
        MDU_MTHI: hi_q <= rs_val;
        MDU_MTLO: lo_q <= rs_val;
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign stall_req = busy_q | (start & is_long_op(op));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  // Reference architectural state.
  logic [31:0] m_hi = '0, m_lo = '0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result of a multiply/divide from plain 64-bit arithmetic.
  function automatic void ref_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic v, output logic [31:0] rh, output logic [31:0] rl);
    int ia, ib;
    longint sa, sb, p, q, r;
    longint unsigned up;
    ia = a; ib = b; sa = ia; sb = ib;
    v = 1'b1; rh = '0; rl = '0;
    case (o)
      3'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
      3'd3: begin
        if (b == 0) v = 1'b0;
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      default: begin
        if (b == 0) v = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
    endcase
  endfunction

  // Issue a multiply/divide at the current negedge and follow it to completion.
  // Optionally pokes a stray MTLO at busy cycle 2, which must be ignored.
  task automatic run_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input bit disturb);
    logic v;
    logic [31:0] nh, nl, oh, ol;
    int n, exp_n;
    exp_n = (o == MDU_MULT || o == MDU_MULTU) ? MC : DC;
    oh = m_hi; ol = m_lo;
    ref_calc(o, a, b, v, nh, nl);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL issue_stall op=%0d got=%b want=1", o, stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      n++;
      checks++;
      if (hi !== oh || lo !== ol || stall_req !== 1'b1) begin
        errors++;
        $display("FAIL hold op=%0d cyc=%0d hi=%h lo=%h stall=%b want hi=%h lo=%h stall=1",
                 o, n, hi, lo, stall_req, oh, ol);
      end
      if (disturb && n == 2) begin
        start = 1'b1; op = MDU_MTLO; rs_val = $urandom; rt_val = $urandom;
      end
    end
    start = 1'b0; op = MDU_NONE;
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL busy_len op=%0d got=%0d want=%0d", o, n, exp_n);
    end
    if (v) begin m_hi = nh; m_lo = nl; end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
               o, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  // Single-edge ops: MTHI, MTLO, NONE, reserved.
  task automatic run_simple(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1; op = o; rs_val = a; rt_val = $urandom;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL simple_stall op=%0d got=%b want=0", o, stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE;
    @(negedge clk);
    if (o == MDU_MTHI) m_hi = a;
    if (o == MDU_MTLO) m_lo = a;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL simple op=%0d got hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               o, hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o >= 3'd1 && o <= 3'd4) run_muldiv(o, a, b, 1'b0);
    else run_simple(o, a);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset busy=%b hi=%h lo=%h stall=%b want all 0", busy, hi, lo, stall_req);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_muldiv(MDU_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL mult_const got hi=%h lo=%h want FFFFFFFF/FFFFFFFA", hi, lo);
    end
    run_muldiv(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    checks++;
    if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      errors++; $display("FAIL multu_const got hi=%h lo=%h want 00000002/FFFFFFFA", hi, lo);
    end
  endtask

  task automatic test_div();
    run_muldiv(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div_const got hi=%h lo=%h want FFFFFFFF/FFFFFFFD", hi, lo);
    end
    run_muldiv(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    checks++;
    if (hi !== 32'd1 || lo !== 32'd3) begin
      errors++; $display("FAIL divu_const got hi=%h lo=%h want 1/3", hi, lo);
    end
    run_muldiv(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf got hi=%h lo=%h want 0/80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    run_simple(MDU_MTHI, 32'h11);
    run_simple(MDU_MTLO, 32'h22);
    run_muldiv(MDU_DIV, 32'h1234, 32'd0, 1'b0);
    run_muldiv(MDU_DIVU, 32'h5678, 32'd0, 1'b0);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL div0_const got hi=%h lo=%h want 11/22", hi, lo);
    end
  endtask

  task automatic test_mt();
    run_simple(MDU_MTLO, 32'hDEADBEEF);
    checks++;
    if (lo !== 32'hDEADBEEF) begin
      errors++; $display("FAIL mtlo_const got lo=%h want DEADBEEF", lo);
    end
    run_simple(MDU_MTHI, 32'hCAFEF00D);
    run_simple(MDU_NONE, 32'h55555555);
    run_simple(MDU_RSVD, 32'hAAAAAAAA);
  endtask

  task automatic test_busy_ignore();
    run_muldiv(MDU_MULT, 32'h00012345, 32'hFFFF0001, 1'b1);
    run_muldiv(MDU_DIVU, 32'hFFFFFFFF, 32'd10, 1'b1);
  endtask

  task automatic test_back_to_back();
    // Each run ends on the first busy=0 cycle, so the next issue lands there.
    run_muldiv(MDU_MULTU, 32'h89ABCDEF, 32'h12345678, 1'b0);
    run_muldiv(MDU_DIV, 32'h7FFFFFFF, 32'hFFFFFFF0, 1'b0);
    run_simple(MDU_MTHI, 32'h0BADF00D);
    run_muldiv(MDU_MULT, 32'h80000000, 32'h80000000, 1'b0);
  endtask

  task automatic test_reset_midflight();
    run_simple(MDU_MTHI, 32'h01010101);
    start = 1'b1; op = MDU_MULT; rs_val = 32'h00001000; rt_val = 32'h00002000;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++;
        $display("FAIL reset_late cyc=%0d busy=%b hi=%h lo=%h want 0/0/0", k, busy, hi, lo);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_op(o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mt();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage pipelined CPU. It consumes MDU operations issued from the D/E pipeline register and holds the architectural HI/LO registers. It applies a multi-cycle busy window and raises a stall request back toward the D stage, so the D/E register does not issue a dependent MDU instruction while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an MDU op; sampled at each rising edge
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- rs_val  input  32  forwarded rs operand in E
- rt_val  input  32  forwarded rt operand in E
- busy  output  1  multi-cycle op in flight (registered)
- stall_req  output  1  combinational: busy | (start & op in {1..4})
- hi  output  32  architectural HI
- lo  output  32  architectural LO

## Operation
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt!=0).
- IDLE, start & op MULT/MULTU: latch the 64-bit product into pend_hi/pend_lo and load cnt=MULT_CYCLES.
  - MULT is signed ($signed × $signed); MULTU is unsigned zero-extended to 64 bits.
- IDLE, start & op DIV/DIVU with rt_val!=0: latch quotient into pend_lo and remainder into pend_hi, then load cnt=DIV_CYCLES.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIV/DIVU with rt_val==0: cnt is loaded and busy runs normally, but HI/LO are left unchanged at completion (pend_valid=0).
- IDLE, start & MTHI: hi<=rs_val at the next edge. start & MTLO: lo<=rs_val at the next edge. No busy window for either.
- RUN: cnt decrements each edge. On the 1→0 transition, hi/lo <= pend_hi/pend_lo (if pend_valid).
- start while busy: ignored, with no state change. The hazard logic guarantees this never happens legally, so the bench checks it as a don't-disturb case.
- op NONE/reserved with start: no effect.

## Timing
- Reset (reset=0, asynchronous): cnt=0, busy=0, hi=0, lo=0, pend_*=0. Any in-flight result is discarded, with no late write after release.
- start with a multiply/divide op sampled at edge T:
  - busy is high from after edge T through edge T+N (N=MULT_CYCLES/DIV_CYCLES), exactly N cycles.
  - The new hi/lo become visible in the same cycle busy falls.
- Between start and completion, hi/lo keep their old values, so MFHI/MFLO must stall via stall_req.
- stall_req is asserted in the issue cycle itself (combinational path on start/op) and for all N busy cycles.
- MTHI/MTLO latency is 1 edge. A simultaneous completion and MT* cannot occur because start is ignored while busy.
- Back-to-back: a new start may be accepted in the first cycle with busy=0.

## Structure
- Shared package mdu_pkg holds:
  - op encodings MDU_NONE..MDU_MTLO (3-bit)
  - default latency constants MULT_CYCLES_DEF=5 and DIV_CYCLES_DEF=10
- The D-stage decoder and the hazard unit both import this package.
- No sub-module; the arithmetic is inline behavioural operators and the counter is 4 bits.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3 → busy exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU rs=0xFFFFFFFE, rt=3 → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles. hi/lo hold their previous values during busy.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- DIV by zero with prior HI=0x11, LO=0x22 → busy 10 cycles; HI/LO remain 0x11/0x22.
- MTLO rs=0xDEADBEEF → lo=0xDEADBEEF one edge later, with busy never asserted. A start issued during busy is ignored and the result is unchanged.
- reset pulsed low at busy cycle 3 of a MULT → hi=lo=0, busy=0 immediately, and no update follows after release.
